shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//   Parametrised, pipelined barrel shifter; successor to the combinational 16-bit left shifter.
//   Supports logical/arithmetic shifts and rotates in both directions, with a carry-out and zero flag.
//   Uses a valid/ready handshake on input and output, with full backpressure.
//   Sits between the ALU operand mux and the writeback stage; one op per cycle at full throughput.
// PARAMETERS
//   WIDTH    16  data width, power of two, >= 4
//   SHAMT_W  5   shift-amount width; must satisfy 2**SHAMT_W > WIDTH
//   NSTG     $clog2(WIDTH)  barrel stages, derived (localparam); stage k shifts by 2**k
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   1        input op present
//   in_ready   out  1        block accepts op this cycle
//   in_a       in   WIDTH    operand
//   in_shamt   in   SHAMT_W  shift amount, unsigned
//   in_mode    in   3        000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others PASS
//   out_valid  out  1        result present
//   out_ready  in   1        consumer takes result this cycle
//   out_y      out  WIDTH    result
//   out_c      out  1        carry-out (last bit shifted out)
//   out_z      out  1        out_y == 0
// BEHAVIOUR
//   Reset: all stage valid bits = 0, so out_valid = 0. Data registers and out_y/out_c/out_z = 0.
//     in_ready = 1 once rst_n is high. An assertion mid-operation discards all in-flight ops immediately.
//   Handshake: transfer occurs on the clk edge where valid && ready. in_a/in_shamt/in_mode are sampled only then.
//     out_y/out_c/out_z stay stable while out_valid && !out_ready.
//   Pipeline: NSTG registered stages, each with its own valid bit v[k].
//     stage k advances when !v[k] || advance[k+1]; the last stage advances when !v[NSTG-1] || out_ready.
//     in_ready = advance[0]; this is a combinational ready chain, and the block adds no bubbles.
//   Latency: NSTG cycles from accepted input to out_valid with no stall (4 for WIDTH=16).
//     Throughput is 1 op/cycle. Capacity is NSTG ops.
//   Input conditioning (before stage 0, no register):
//     amt = in_shamt. For rotates, eff = amt mod WIDTH.
//     For shifts with amt >= WIDTH: SLL/SRL give y = 0 and SRA gives y = {WIDTH{a[MSB]}}.
//     These cases are flagged and forced at the output; the barrel runs with amount 0.
//   Carry (computed at input, carried down the pipe):
//     any mode with amt == 0 -> 0.
//     SLL: 1 <= amt <= WIDTH -> a[WIDTH-amt]; amt > WIDTH -> 0.
//     SRL: 1 <= amt <= WIDTH -> a[amt-1]; amt > WIDTH -> 0.
//     SRA: 1 <= amt <= WIDTH -> a[amt-1]; amt > WIDTH -> a[MSB].
//     ROL: carry = y[0]. ROR: carry = y[MSB]. Both are 0 when eff == 0.
//     PASS: carry = 0.
//   Barrel: stage k applies shift/rotate by 2**k when eff bit k = 1. Fill is 0 for SLL/SRL and sign for SRA.
//     For rotates, wrapped bits re-enter from the opposite end.
//     The SRA sign bit is taken from the original operand, not from intermediate values.
//   PASS and unused modes: y = in_a, c = 0.
//   out_z is computed from the final y, registered with it.
//   Simultaneous in-accept and out-take with a full pipe is legal and keeps throughput at 1/cycle.
//   Ops retire in strict order of acceptance.
// TESTING (WIDTH=16, SHAMT_W=5)
//   T1 SLL a=0x00FF shamt=4 -> y=0x0FF0 c=0 z=0, out_valid exactly 4 cycles after accept.
//   T2 SRA a=0x8000 shamt=15 -> y=0xFFFF c=0. SRA a=0x8000 shamt=20 -> y=0xFFFF c=1.
//      SRL a=0x8000 shamt=15 -> y=0x0001 c=0.
//   T3 SLL a=0x8001 shamt=16 -> y=0x0000 c=1 z=1. shamt=17 -> y=0x0000 c=0 z=1.
//      shamt=0 -> y=0x8001 c=0.
//   T4 ROR a=0x1234 shamt=20 -> y=0x4123 c=0. ROL a=0x8001 shamt=1 -> y=0x0003 c=1.
//      mode=111 a=0xABCD -> y=0xABCD c=0.
//   T5 stream 8 ops back-to-back with out_ready=0 for cycles 3-8:
//      in_ready drops after 4 accepts; out_y is held stable; on release all 8 results arrive
//      in order with no loss or duplicate.
//   T6 rst_n low with 3 ops in flight -> out_valid=0 asynchronously.
//      After release, in_ready=1, no stale results, and a new op completes normally.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR/PASS) with carry-out and zero flag.
// One barrel stage per register, valid/ready handshake with full backpressure.
module shifter_pipe #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_c,
  output logic               out_z
);
  localparam int unsigned        NSTG  = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] W_AMT = SHAMT_W'(WIDTH);
  localparam logic [WIDTH-1:0]   ONES  = '1;

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_PASS = 3'b111
  } op_e;

  function automatic logic [WIDTH-1:0] f_stage(input logic [WIDTH-1:0] d, input op_e op,
                                               input logic fill, input int unsigned s);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = (d >> s) | (fill ? ~(ONES >> s) : '0);
      OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
      OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
      default: r = d;
    endcase
    return r;
  endfunction

  op_e             w_op;
  logic [NSTG-1:0] w_lo, w_neg, w_dec, w_eff;
  logic            w_big, w_eqw, w_zero, w_force, w_fill, w_c;

  assign w_lo   = in_shamt[NSTG-1:0];
  assign w_neg  = -w_lo;
  assign w_dec  = w_lo - NSTG'(1);
  assign w_big  = (in_shamt >= W_AMT);
  assign w_eqw  = (in_shamt == W_AMT);
  assign w_zero = (in_shamt == '0);

  // Carry indices: a[WIDTH-amt] == a[-amt mod WIDTH], a[amt-1] == a[(amt-1) mod WIDTH].
  always_comb begin
    case (in_mode)
      3'b000:  w_op = OP_SLL;
      3'b001:  w_op = OP_SRL;
      3'b010:  w_op = OP_SRA;
      3'b011:  w_op = OP_ROL;
      3'b100:  w_op = OP_ROR;
      default: w_op = OP_PASS;
    endcase
    w_eff   = '0;
    w_force = 1'b0;
    w_fill  = 1'b0;
    w_c     = 1'b0;
    case (w_op)
      OP_SLL: begin
        w_force = w_big;
        w_eff   = w_big ? '0 : w_lo;
        w_c     = (!w_zero && (!w_big || w_eqw)) ? in_a[w_neg] : 1'b0;
      end
      OP_SRL: begin
        w_force = w_big;
        w_eff   = w_big ? '0 : w_lo;
        w_c     = (!w_zero && (!w_big || w_eqw)) ? in_a[w_dec] : 1'b0;
      end
      OP_SRA: begin
        w_force = w_big;
        w_fill  = in_a[WIDTH-1];
        w_eff   = w_big ? '0 : w_lo;
        w_c     = w_zero ? 1'b0 : ((w_big && !w_eqw) ? in_a[WIDTH-1] : in_a[w_dec]);
      end
      OP_ROL: begin
        w_eff = w_lo;
        w_c   = (w_lo != '0) ? in_a[w_neg] : 1'b0;
      end
      OP_ROR: begin
        w_eff = w_lo;
        w_c   = (w_lo != '0) ? in_a[w_dec] : 1'b0;
      end
      default: ;
    endcase
  end

  logic             r_v     [NSTG];
  logic [WIDTH-1:0] r_d     [NSTG];
  op_e              r_op    [NSTG];
  logic [NSTG-1:0]  r_amt   [NSTG];
  logic             r_force [NSTG];
  logic             r_fill  [NSTG];
  logic             r_c     [NSTG];
  logic             r_z;
  logic [NSTG-1:0]  w_v;
  logic [NSTG-1:0]  w_adv;

  for (genvar K = 0; K < NSTG; K++) begin : g_stg
    logic             w_sv, w_sforce, w_sfill, w_sc;
    logic [WIDTH-1:0] w_sd, w_nd;
    op_e              w_sop;
    logic [NSTG-1:0]  w_samt;

    assign w_v[K] = r_v[K];
    // Closed form of the ready chain: stage K moves if the consumer takes or any slot at or after K is empty.
    assign w_adv[K] = out_ready || !(&w_v[NSTG-1:K]);

    if (K == 0) begin : g_head
      assign w_sv     = in_valid;
      assign w_sd     = in_a;
      assign w_sop    = w_op;
      assign w_samt   = w_eff;
      assign w_sforce = w_force;
      assign w_sfill  = w_fill;
      assign w_sc     = w_c;
    end else begin : g_body
      assign w_sv     = r_v[K-1];
      assign w_sd     = r_d[K-1];
      assign w_sop    = r_op[K-1];
      assign w_samt   = r_amt[K-1];
      assign w_sforce = r_force[K-1];
      assign w_sfill  = r_fill[K-1];
      assign w_sc     = r_c[K-1];
    end

    always_comb begin
      w_nd = w_samt[K] ? f_stage(w_sd, w_sop, w_sfill, 2**K) : w_sd;
      if (K == NSTG-1 && w_sforce) w_nd = {WIDTH{w_sfill}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[K]     <= 1'b0;
        r_d[K]     <= '0;
        r_op[K]    <= OP_PASS;
        r_amt[K]   <= '0;
        r_force[K] <= 1'b0;
        r_fill[K]  <= 1'b0;
        r_c[K]     <= 1'b0;
      end else if (w_adv[K]) begin
        r_v[K]     <= w_sv;
        r_d[K]     <= w_nd;
        r_op[K]    <= w_sop;
        r_amt[K]   <= w_samt;
        r_force[K] <= w_sforce;
        r_fill[K]  <= w_sfill;
        r_c[K]     <= w_sc;
      end
    end

    if (K == NSTG-1) begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_z <= 1'b0;
        else if (w_adv[K])   r_z <= (w_nd == '0);
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[NSTG-1];
  assign out_y     = r_d[NSTG-1];
  assign out_c     = r_c[NSTG-1];
  assign out_z     = r_z;
endmodule

// File: tb/tb_shifter_pipe.sv
// Directed self-checking bench for shifter_pipe (WIDTH=16, SHAMT_W=5).
module tb_shifter_pipe;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SHAMT_W = 5;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_c, out_z;
  logic [15:0] in_a, out_y;
  logic [4:0]  in_shamt;
  logic [2:0]  in_mode;
  int          n_checks, n_errors;

  shifter_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_c(out_c), .out_z(out_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [15:0] a, input logic [4:0] sh, input logic [2:0] m,
                        output logic [15:0] y, output logic c, output logic z, output int lat);
    y = 'x; c = 1'bx; z = 1'bx; lat = -1;
    out_ready = 1'b1;
    in_a = a; in_shamt = sh; in_mode = m; in_valid = 1'b1;
    for (int i = 0; i < 16 && !in_ready; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (out_valid) begin y = out_y; c = out_c; z = out_z; lat = i; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_y !== 16'h0000) begin n_errors++; $display("FAIL rst_out_y got %h want 0000", out_y); end
    n_checks++; if (out_c !== 1'b0) begin n_errors++; $display("FAIL rst_out_c got %b want 0", out_c); end
    n_checks++; if (out_z !== 1'b0) begin n_errors++; $display("FAIL rst_out_z got %b want 0", out_z); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_sll_latency;
    logic [15:0] y; logic c, z; int lat;
    run_op(16'h00FF, 5'd4, 3'b000, y, c, z, lat);
    n_checks++; if (y !== 16'h0FF0) begin n_errors++; $display("FAIL t1_y got %h want 0ff0", y); end
    n_checks++; if (c !== 1'b0) begin n_errors++; $display("FAIL t1_c got %b want 0", c); end
    n_checks++; if (z !== 1'b0) begin n_errors++; $display("FAIL t1_z got %b want 0", z); end
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL t1_latency got %0d want 4", lat); end
  endtask

  task automatic test_shift_right;
    logic [15:0] y; logic c, z; int lat;
    run_op(16'h8000, 5'd15, 3'b010, y, c, z, lat);
    n_checks++; if (y !== 16'hFFFF) begin n_errors++; $display("FAIL sra15_y got %h want ffff", y); end
    n_checks++; if (c !== 1'b0) begin n_errors++; $display("FAIL sra15_c got %b want 0", c); end
    run_op(16'h8000, 5'd20, 3'b010, y, c, z, lat);
    n_checks++; if (y !== 16'hFFFF) begin n_errors++; $display("FAIL sra20_y got %h want ffff", y); end
    n_checks++; if (c !== 1'b1) begin n_errors++; $display("FAIL sra20_c got %b want 1", c); end
    run_op(16'h8000, 5'd15, 3'b001, y, c, z, lat);
    n_checks++; if (y !== 16'h0001) begin n_errors++; $display("FAIL srl15_y got %h want 0001", y); end
    n_checks++; if (c !== 1'b0) begin n_errors++; $display("FAIL srl15_c got %b want 0", c); end
    run_op(16'h00F8, 5'd4, 3'b001, y, c, z, lat);
    n_checks++; if (y !== 16'h000F) begin n_errors++; $display("FAIL srl4_y got %h want 000f", y); end
    n_checks++; if (c !== 1'b1) begin n_errors++; $display("FAIL srl4_c got %b want 1", c); end
  endtask

  task automatic test_sll_bounds;
    logic [15:0] y; logic c, z; int lat;
    run_op(16'h8001, 5'd16, 3'b000, y, c, z, lat);
    n_checks++; if (y !== 16'h0000) begin n_errors++; $display("FAIL sll16_y got %h want 0000", y); end
    n_checks++; if (c !== 1'b1) begin n_errors++; $display("FAIL sll16_c got %b want 1", c); end
    n_checks++; if (z !== 1'b1) begin n_errors++; $display("FAIL sll16_z got %b want 1", z); end
    run_op(16'h8001, 5'd17, 3'b000, y, c, z, lat);
    n_checks++; if (y !== 16'h0000) begin n_errors++; $display("FAIL sll17_y got %h want 0000", y); end
    n_checks++; if (c !== 1'b0) begin n_errors++; $display("FAIL sll17_c got %b want 0", c); end
    n_checks++; if (z !== 1'b1) begin n_errors++; $display("FAIL sll17_z got %b want 1", z); end
    run_op(16'h8001, 5'd0, 3'b000, y, c, z, lat);
    n_checks++; if (y !== 16'h8001) begin n_errors++; $display("FAIL sll0_y got %h want 8001", y); end
    n_checks++; if (c !== 1'b0) begin n_errors++; $display("FAIL sll0_c got %b want 0", c); end
  endtask

  task automatic test_rotate_pass;
    logic [15:0] y; logic c, z; int lat;
    run_op(16'h1234, 5'd20, 3'b100, y, c, z, lat);
    n_checks++; if (y !== 16'h4123) begin n_errors++; $display("FAIL ror20_y got %h want 4123", y); end
    n_checks++; if (c !== 1'b0) begin n_errors++; $display("FAIL ror20_c got %b want 0", c); end
    run_op(16'h8001, 5'd1, 3'b011, y, c, z, lat);
    n_checks++; if (y !== 16'h0003) begin n_errors++; $display("FAIL rol1_y got %h want 0003", y); end
    n_checks++; if (c !== 1'b1) begin n_errors++; $display("FAIL rol1_c got %b want 1", c); end
    run_op(16'hABCD, 5'd7, 3'b111, y, c, z, lat);
    n_checks++; if (y !== 16'hABCD) begin n_errors++; $display("FAIL pass7_y got %h want abcd", y); end
    n_checks++; if (c !== 1'b0) begin n_errors++; $display("FAIL pass7_c got %b want 0", c); end
    run_op(16'h5A5A, 5'd3, 3'b101, y, c, z, lat);
    n_checks++; if (y !== 16'h5A5A) begin n_errors++; $display("FAIL pass5_y got %h want 5a5a", y); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_y [8];
    logic [15:0] held_y;
    logic        held_v;
    int          sent, recv, acc_at_drop;
    exp_y = '{16'h1234, 16'h2468, 16'h48D0, 16'h91A0, 16'h2341, 16'h4682, 16'h8D04, 16'h1A09};
    sent = 0; recv = 0; acc_at_drop = -1; held_v = 1'b0; held_y = '0;
    for (int cyc = 1; cyc <= 80 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 8);
      in_valid  = (sent < 8);
      in_a      = 16'h1234;
      in_shamt  = 5'(sent);
      in_mode   = 3'b011;
      #1;
      if (held_v) begin
        n_checks++;
        if (out_y !== held_y) begin n_errors++; $display("FAIL b2b_hold got %h want %h", out_y, held_y); end
      end
      if (in_valid && !in_ready && acc_at_drop < 0) acc_at_drop = sent;
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_y !== exp_y[recv]) begin n_errors++; $display("FAIL b2b_result%0d got %h want %h", recv, out_y, exp_y[recv]); end
        recv++;
      end
      held_v = out_valid && !out_ready;
      held_y = out_y;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (acc_at_drop !== 4) begin n_errors++; $display("FAIL b2b_ready_drop got %0d want 4", acc_at_drop); end
    n_checks++; if (recv !== 8) begin n_errors++; $display("FAIL b2b_count got %0d want 8", recv); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_extra got %b want 0", out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_inflight;
    logic [15:0] y; logic c, z; int lat;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'h0001; in_shamt = 5'(i + 1); in_mode = 3'b000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    n_checks++; if (out_y !== 16'h0000) begin n_errors++; $display("FAIL rst_async_y got %h want 0000", out_y); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_post_ready got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_stale got %b want 0", out_valid); end
      @(posedge clk); #1;
    end
    run_op(16'h000F, 5'd4, 3'b100, y, c, z, lat);
    n_checks++; if (y !== 16'hF000) begin n_errors++; $display("FAIL rst_new_y got %h want f000", y); end
    n_checks++; if (c !== 1'b1) begin n_errors++; $display("FAIL rst_new_c got %b want 1", c); end
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL rst_new_latency got %0d want 4", lat); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_sll_latency();
    test_shift_right();
    test_sll_bounds();
    test_rotate_pass();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
